// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word/register types, ALU opcodes and EX/MEM latch layout
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    localparam regbits_t LINK_REG = 5'd31;

    typedef struct packed {
        word_t    aluout;
        word_t    storedat;
        word_t    pcplus4;
        regbits_t wsel;
        logic     regwen;
        logic     memtoreg;
        logic     dmemwen;
        logic     dmemren;
        logic     halt;
    } exmem_t;

    // MEM wins over WB; register 0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_select(input regbits_t src,
                                            input logic     mem_wen,
                                            input regbits_t mem_wsel,
                                            input logic     wb_wen,
                                            input regbits_t wb_wsel);
        if (mem_wen && (mem_wsel != '0) && (mem_wsel == src))
            return FWD_MEM;
        else if (wb_wen && (wb_wsel != '0) && (wb_wsel == src))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; shifts operate on b_i by shamt_i
module alu
    import cpu_types_pkg::*;
(
    input  aluop_t      op_i,
    input  word_t       a_i,
    input  word_t       b_i,
    input  logic [4:0]  shamt_i,
    output word_t       result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - execute stage with forwarding, branch resolution and EX/MEM latch
module exmem_stage
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic         writeEN,
    input  logic         flush,
    input  word_t        pcplus4_in,
    input  word_t        rdat1_in,
    input  word_t        rdat2_in,
    input  word_t        immext_in,
    input  regbits_t     rs_in,
    input  regbits_t     rt_in,
    input  regbits_t     rd_in,
    input  logic [4:0]   shamt_in,
    input  aluop_t       AluOp_in,
    input  logic         AluSrc_in,
    input  logic         RegDst_in,
    input  logic         Jal_in,
    input  logic         Lui_in,
    input  logic         regWEN_in,
    input  logic         MemToReg_in,
    input  logic         dMemWEN_in,
    input  logic         dMemREN_in,
    input  logic         Halt_in,
    input  logic         Beq_in,
    input  logic         Bne_in,
    input  logic         JType_in,
    input  logic         JReg_in,
    input  logic [25:0]  jaddr_in,
    input  logic         wb_regWEN,
    input  regbits_t     wb_wsel,
    input  word_t        wb_wdat,
    output logic         branch_taken,
    output word_t        branch_target,
    output word_t        aluout_out,
    output word_t        storedat_out,
    output word_t        pcplus4_out,
    output regbits_t     wsel_out,
    output logic         regWEN_out,
    output logic         MemToReg_out,
    output logic         dMemWEN_out,
    output logic         dMemREN_out,
    output logic         Halt_out
);

    exmem_t   latch_q, latch_d, computed;
    fwd_sel_t sel_a, sel_b;
    word_t    fwd_a, fwd_b;
    word_t    alu_b, alu_result;
    aluop_t   alu_op;
    logic     alu_zero;
    logic     is_branch;

    assign sel_a = fwd_select(rs_in, latch_q.regwen, latch_q.wsel, wb_regWEN, wb_wsel);
    assign sel_b = fwd_select(rt_in, latch_q.regwen, latch_q.wsel, wb_regWEN, wb_wsel);

    always_comb begin
        fwd_a = rdat1_in;
        fwd_b = rdat2_in;
        case (sel_a)
            FWD_MEM: fwd_a = latch_q.aluout;
            FWD_WB:  fwd_a = wb_wdat;
            default: fwd_a = rdat1_in;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = latch_q.aluout;
            FWD_WB:  fwd_b = wb_wdat;
            default: fwd_b = rdat2_in;
        endcase
    end

    // Conditional branches borrow the ALU as a subtractor so its zero flag is A==B.
    assign is_branch = Beq_in || Bne_in;
    assign alu_op    = is_branch ? ALU_SUB : AluOp_in;
    assign alu_b     = (AluSrc_in && !is_branch) ? immext_in : fwd_b;

    alu u_alu (
        .op_i     (alu_op),
        .a_i      (fwd_a),
        .b_i      (alu_b),
        .shamt_i  (shamt_in),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        branch_taken = (Beq_in && alu_zero) || (Bne_in && !alu_zero) || JType_in || JReg_in;
        if (latch_q.halt || !writeEN)
            branch_taken = 1'b0;

        if (JReg_in)
            branch_target = fwd_a;
        else if (JType_in)
            branch_target = {pcplus4_in[31:28], jaddr_in, 2'b00};
        else
            branch_target = pcplus4_in + (immext_in << 2);
    end

    always_comb begin
        computed          = '0;
        computed.aluout   = Jal_in ? pcplus4_in
                          : (Lui_in ? {immext_in[15:0], 16'h0000} : alu_result);
        computed.storedat = fwd_b;
        computed.pcplus4  = pcplus4_in;
        computed.wsel     = Jal_in ? LINK_REG : (RegDst_in ? rd_in : rt_in);
        computed.regwen   = regWEN_in;
        computed.memtoreg = MemToReg_in;
        computed.dmemwen  = dMemWEN_in;
        computed.dmemren  = dMemREN_in;
        computed.halt     = Halt_in;
    end

    // A latched halt freezes the latch until reset, regardless of flush or writeEN.
    always_comb begin
        latch_d = latch_q;
        if (!latch_q.halt) begin
            if (flush)
                latch_d = '0;
            else if (writeEN)
                latch_d = computed;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            latch_q <= '0;
        else
            latch_q <= latch_d;
    end

    assign aluout_out   = latch_q.aluout;
    assign storedat_out = latch_q.storedat;
    assign pcplus4_out  = latch_q.pcplus4;
    assign wsel_out     = latch_q.wsel;
    assign regWEN_out   = latch_q.regwen;
    assign MemToReg_out = latch_q.memtoreg;
    assign dMemWEN_out  = latch_q.dmemwen;
    assign dMemREN_out  = latch_q.dmemren;
    assign Halt_out     = latch_q.halt;

endmodule

// File: tb/tb_exmem_stage.sv
// tb/tb_exmem_stage.sv - directed self-checking bench for exmem_stage
module tb_exmem_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        writeEN, flush;
    word_t       pcplus4_in, rdat1_in, rdat2_in, immext_in;
    regbits_t    rs_in, rt_in, rd_in;
    logic [4:0]  shamt_in;
    aluop_t      AluOp_in;
    logic        AluSrc_in, RegDst_in, Jal_in, Lui_in;
    logic        regWEN_in, MemToReg_in, dMemWEN_in, dMemREN_in, Halt_in;
    logic        Beq_in, Bne_in, JType_in, JReg_in;
    logic [25:0] jaddr_in;
    logic        wb_regWEN;
    regbits_t    wb_wsel;
    word_t       wb_wdat;
    logic        branch_taken;
    word_t       branch_target, aluout_out, storedat_out, pcplus4_out;
    regbits_t    wsel_out;
    logic        regWEN_out, MemToReg_out, dMemWEN_out, dMemREN_out, Halt_out;

    int checks = 0;
    int errors = 0;

    exmem_stage dut (
        .CLK(CLK), .nRST(nRST), .writeEN(writeEN), .flush(flush),
        .pcplus4_in(pcplus4_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in),
        .immext_in(immext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .shamt_in(shamt_in), .AluOp_in(AluOp_in), .AluSrc_in(AluSrc_in),
        .RegDst_in(RegDst_in), .Jal_in(Jal_in), .Lui_in(Lui_in),
        .regWEN_in(regWEN_in), .MemToReg_in(MemToReg_in), .dMemWEN_in(dMemWEN_in),
        .dMemREN_in(dMemREN_in), .Halt_in(Halt_in), .Beq_in(Beq_in), .Bne_in(Bne_in),
        .JType_in(JType_in), .JReg_in(JReg_in), .jaddr_in(jaddr_in),
        .wb_regWEN(wb_regWEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .aluout_out(aluout_out), .storedat_out(storedat_out), .pcplus4_out(pcplus4_out),
        .wsel_out(wsel_out), .regWEN_out(regWEN_out), .MemToReg_out(MemToReg_out),
        .dMemWEN_out(dMemWEN_out), .dMemREN_out(dMemREN_out), .Halt_out(Halt_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        writeEN = 1'b1; flush = 1'b0;
        pcplus4_in = '0; rdat1_in = '0; rdat2_in = '0; immext_in = '0;
        rs_in = '0; rt_in = '0; rd_in = '0; shamt_in = '0;
        AluOp_in = ALU_ADD; AluSrc_in = 1'b0; RegDst_in = 1'b1; Jal_in = 1'b0; Lui_in = 1'b0;
        regWEN_in = 1'b0; MemToReg_in = 1'b0; dMemWEN_in = 1'b0; dMemREN_in = 1'b0;
        Halt_in = 1'b0; Beq_in = 1'b0; Bne_in = 1'b0; JType_in = 1'b0; JReg_in = 1'b0;
        jaddr_in = '0; wb_regWEN = 1'b0; wb_wsel = '0; wb_wdat = '0;
    endtask

    typedef struct {
        aluop_t     op;
        word_t      a;
        word_t      b;
        logic [4:0] sh;
        word_t      exp;
        string      tag;
    } alu_vec_t;

    alu_vec_t alu_vecs[8];

    initial begin
        alu_vecs[0] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         "slt_signed"};
        alu_vecs[1] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         "sltu_unsigned"};
        alu_vecs[2] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, "add_wrap"};
        alu_vecs[3] = '{ALU_SLL,  32'h0,         32'h1,         5'd31, 32'h8000_0000, "sll_31"};
        alu_vecs[4] = '{ALU_SUB,  32'h3,         32'h5,         5'd0,  32'hFFFF_FFFE, "sub_neg"};
        alu_vecs[5] = '{ALU_NOR,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, "nor_zero"};
        alu_vecs[6] = '{ALU_SRL,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, "srl_4"};
        alu_vecs[7] = '{ALU_XOR,  32'hF0F0,      32'hFF00,      5'd0,  32'h0FF0,      "xor"};

        clear_inputs();
        nRST = 1'b0;
        #12 nRST = 1'b1;
        step();
        chk("rst_aluout", aluout_out, 32'h0);
        chk("rst_halt", {31'd0, Halt_out}, 32'h0);

        // Async reset mid-cycle
        rdat1_in = 32'd3; rdat2_in = 32'd4; rd_in = 5'd9; regWEN_in = 1'b1; pcplus4_in = 32'h44;
        step();
        chk("load_aluout", aluout_out, 32'd7);
        chk("load_wsel", {27'd0, wsel_out}, 32'd9);
        #2 nRST = 1'b0;
        #1;
        chk("async_aluout", aluout_out, 32'h0);
        chk("async_wsel", {27'd0, wsel_out}, 32'h0);
        chk("async_regwen", {31'd0, regWEN_out}, 32'h0);
        chk("async_pc4", pcplus4_out, 32'h0);
        nRST = 1'b1;
        clear_inputs();

        // Forwarding
        rdat1_in = 32'h10; rd_in = 5'd5; regWEN_in = 1'b1;
        step();
        rs_in = 5'd5; rdat1_in = 32'hAA; rd_in = 5'd0;
        wb_regWEN = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h20;
        step();
        chk("fwd_mem_beats_wb", aluout_out, 32'h10);
        step();
        chk("fwd_wb", aluout_out, 32'h20);
        rs_in = 5'd0; wb_wsel = 5'd0;
        step();
        chk("fwd_r0_never", aluout_out, 32'hAA);
        wb_regWEN = 1'b0;
        rdat1_in = 32'h30; rd_in = 5'd7;
        step();
        rdat1_in = 32'h1; rt_in = 5'd7; rdat2_in = 32'h99; rd_in = 5'd0;
        step();
        chk("fwd_mem_b", aluout_out, 32'h31);
        chk("fwd_store", storedat_out, 32'h30);

        // ALU operations
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            AluOp_in = alu_vecs[i].op; rdat1_in = alu_vecs[i].a;
            rdat2_in = alu_vecs[i].b; shamt_in = alu_vecs[i].sh;
            step();
            chk(alu_vecs[i].tag, aluout_out, alu_vecs[i].exp);
        end
        clear_inputs();
        AluSrc_in = 1'b1; rdat1_in = 32'h10; immext_in = 32'h4; rdat2_in = 32'h1000;
        step();
        chk("alusrc_imm", aluout_out, 32'h14);
        chk("alusrc_store", storedat_out, 32'h1000);
        AluSrc_in = 1'b0; Lui_in = 1'b1; immext_in = 32'h1234;
        step();
        chk("lui", aluout_out, 32'h1234_0000);

        // Branch and jump resolution (combinational)
        clear_inputs();
        Beq_in = 1'b1; rdat1_in = 32'd7; rdat2_in = 32'd7; pcplus4_in = 32'h100; immext_in = 32'd4;
        #1;
        chk("beq_taken", {31'd0, branch_taken}, 32'h1);
        chk("beq_target", branch_target, 32'h110);
        Beq_in = 1'b0; Bne_in = 1'b1;
        #1;
        chk("bne_equal", {31'd0, branch_taken}, 32'h0);
        rdat2_in = 32'd8;
        #1;
        chk("bne_diff", {31'd0, branch_taken}, 32'h1);
        Bne_in = 1'b0; JReg_in = 1'b1; rdat1_in = 32'h400;
        #1;
        chk("jr_taken", {31'd0, branch_taken}, 32'h1);
        chk("jr_target", branch_target, 32'h400);
        writeEN = 1'b0;
        #1;
        chk("jr_stalled", {31'd0, branch_taken}, 32'h0);
        writeEN = 1'b1; JReg_in = 1'b0; JType_in = 1'b1;
        pcplus4_in = 32'hA000_0004; jaddr_in = 26'h10;
        #1;
        chk("j_target", branch_target, 32'hA000_0040);

        // Stall and flush
        clear_inputs();
        rdat1_in = 32'd1; rdat2_in = 32'd2; rd_in = 5'd4; regWEN_in = 1'b1; pcplus4_in = 32'h44;
        step();
        writeEN = 1'b0; rdat1_in = 32'h50;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", aluout_out, 32'd3);
        end
        chk("stall_wsel", {27'd0, wsel_out}, 32'd4);
        flush = 1'b1; writeEN = 1'b1;
        step();
        chk("flush_aluout", aluout_out, 32'h0);
        chk("flush_wsel", {27'd0, wsel_out}, 32'h0);
        chk("flush_regwen", {31'd0, regWEN_out}, 32'h0);
        chk("flush_pc4", pcplus4_out, 32'h0);
        flush = 1'b0;
        step();
        chk("reload", aluout_out, 32'h52);
        flush = 1'b1; writeEN = 1'b0;
        step();
        chk("flush_no_wen", aluout_out, 32'h0);
        flush = 1'b0; writeEN = 1'b1;
        Jal_in = 1'b1; JType_in = 1'b1; pcplus4_in = 32'h200;
        step();
        chk("jal_wsel", {27'd0, wsel_out}, 32'd31);
        chk("jal_aluout", aluout_out, 32'h200);
        chk("jal_pc4", pcplus4_out, 32'h200);

        // Sticky halt
        clear_inputs();
        Halt_in = 1'b1; rdat1_in = 32'h55;
        step();
        chk("halt_set", {31'd0, Halt_out}, 32'h1);
        chk("halt_aluout", aluout_out, 32'h55);
        Halt_in = 1'b0; flush = 1'b1; rdat1_in = 32'h77; JType_in = 1'b1;
        #1;
        chk("halt_no_branch", {31'd0, branch_taken}, 32'h0);
        step();
        chk("halt_ignore_flush", aluout_out, 32'h55);
        chk("halt_sticky", {31'd0, Halt_out}, 32'h1);
        flush = 1'b0;
        step();
        chk("halt_ignore_wen", aluout_out, 32'h55);
        #2 nRST = 1'b0;
        #1;
        chk("halt_reset", {31'd0, Halt_out}, 32'h0);
        nRST = 1'b1; JType_in = 1'b0; rdat1_in = 32'h66;
        step();
        chk("post_halt_load", aluout_out, 32'h66);
        chk("post_halt_flag", {31'd0, Halt_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
# exmem_stage

Execute stage plus EX/MEM pipeline register of the five-stage MIPS pipeline; sits directly downstream of the ID/EX latch and consumes its outputs. Resolves operand forwarding from MEM and WB, computes the ALU result, store data and destination register, resolves branches and jumps to redirect fetch, and registers everything into the EX/MEM latch under stall/flush control.

## Interface
- No parameters; widths come from `cpu_types_pkg` (word_t 32, regbits_t 5, aluop_t).
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- writeEN  in  1  latch enable; low = stall, hold contents
- flush  in  1  load a bubble into the latch
- pcplus4_in, rdat1_in, rdat2_in, immext_in  in  32 each  from ID/EX
- rs_in, rt_in, rd_in  in  5 each  register fields; shamt_in  in  5
- AluOp_in  in  aluop_t;  AluSrc_in, RegDst_in, Jal_in, Lui_in  in  1 each
- regWEN_in, MemToReg_in, dMemWEN_in, dMemREN_in, Halt_in  in  1 each
- Beq_in, Bne_in, JType_in, JReg_in  in  1 each;  jaddr_in  in  26
- wb_regWEN, wb_wsel, wb_wdat  in  1/5/32  WB-stage write port for forwarding
- branch_taken  out  1  combinational redirect request to fetch
- branch_target  out  32  combinational redirect address
- aluout_out, storedat_out, pcplus4_out  out  32 each  registered
- wsel_out  out  5;  regWEN_out, MemToReg_out, dMemWEN_out, dMemREN_out, Halt_out  out  1 each  registered

## Operation
- Forwarding per operand (A from rs, B from rt): if regWEN_out && wsel_out!=0 && wsel_out==src → aluout_out (MEM); else if wb_regWEN && wb_wsel!=0 && wb_wsel==src → wb_wdat; else rdat. MEM beats WB. Register 0 never forwarded. Load-in-MEM hazards are stalled upstream; this block does not detect them.
- Operand B to ALU = AluSrc_in ? immext_in : forwarded rt. storedat = forwarded rt.
- ALU ops: SLL/SRL shift forwarded rt by shamt_in; ADD/SUB wrap mod 2^32, overflow ignored; AND/OR/XOR/NOR bitwise; SLT signed, SLTU unsigned, result 0 or 1.
- Result override: Lui_in → {immext_in[15:0],16'h0}; Jal_in → pcplus4_in.
- wsel = Jal_in ? 31 : (RegDst_in ? rd_in : rt_in).
- branch_taken = (Beq_in && A==B) || (Bne_in && A!=B) || JType_in || JReg_in, using forwarded A/B.
- branch_target: branch → pcplus4_in + (immext_in<<2); JType → {pcplus4_in[31:28], jaddr_in, 2'b00}; JReg → forwarded A.
- branch_taken forced 0 while Halt_out=1 or writeEN=0.
- Latch: flush → all outputs 0 (bubble); else writeEN → load computed values; else hold.
- Halt sticky: once Halt_out=1, latch ignores writeEN and flush until reset.

## Timing
- Reset: every registered output 0 immediately on nRST low, async.
- Latency 1 cycle: values computed in cycle N appear at outputs after edge N+1.
- branch_taken/target valid in the same cycle the instruction sits in EX; fetch/hazard unit flushes IF/ID and ID/EX on that edge.
- flush and writeEN both high → flush wins. flush with writeEN low → still flushes.
- Forwarding reads current latch outputs, so back-to-back dependent ALU instructions need no stall.
- Reset mid-stall or mid-halt clears the halt lock.

## Structure
- Add to `cpu_types_pkg`: fwd_sel_t enum {FWD_NONE, FWD_MEM, FWD_WB}; reuse aluop_t, word_t, regbits_t.
- One sub-module: `alu` (combinational, ops above, outputs result and zero flag). Forwarding, branch logic, latch stay in `exmem_stage`.

## Test plan
- Reset: drive values, pulse nRST low mid-cycle → all outputs 0 before next edge.
- Forwarding: MEM wsel=5 aluout=0x10, WB wsel=5 wdat=0x20, rs_in=5, ADD rt=0 → aluout_out=0x10; set MEM wsel=0 → 0x20; rs_in=0 → rdat1_in used.
- ALU: SLT 0xFFFFFFFF vs 1 → 1; SLTU → 0; ADD 0x7FFFFFFF+1 → 0x80000000; SLL rt=1 shamt=31 → 0x80000000.
- Branch: BEQ A=B=7, pcplus4=0x100, imm=4 → taken, target 0x110; BNE same operands → not taken; JR A=0x400 → target 0x400.
- Stall/flush: writeEN=0 holds outputs 3 cycles; flush+writeEN → all 0; JAL → wsel 31, aluout=pcplus4.
- Halt: Halt_in with writeEN → Halt_out=1, subsequent flush/new inputs ignored, branch_taken 0 until reset.
